// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: owns the fetch PC, issues word reads to imem and
// registers each returned word (with a one-entry skid) for decode.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget,
  input  logic        Stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        Instr_valid
);

  localparam logic [31:0] START_PC =
    RESET_PC & 32'hFFFF_FFFC;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {
    S_REQ,
    S_HOLD
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        kill_q, kill_d;
  logic [31:0] kill_addr_q, kill_addr_d;
  logic [31:0] skid_q, skid_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;

  logic consume;
  logic load_ok;
  logic redir;

  assign consume = valid_q && !Stall;
  assign load_ok = !valid_q || !Stall;
  assign redir   = PCSrc && !Stall;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    kill_d      = kill_q;
    kill_addr_d = kill_addr_q;
    skid_d      = skid_q;
    skid_pc_d   = skid_pc_q;
    instr_d     = instr_q;
    pc_d        = pc_q;
    valid_d     = valid_q;

    if (redir) begin
      valid_d    = 1'b0;
      state_d    = S_REQ;
      fetch_pc_d = PCTarget & 32'hFFFF_FFFC;
      // keep the in-flight address stable until memory answers
      if (state_q == S_REQ && !imem_ready) begin
        kill_d = 1'b1;
        if (!kill_q) begin
          kill_addr_d = fetch_pc_q;
        end
      end else begin
        kill_d = 1'b0;
      end
    end else begin
      if (consume) begin
        valid_d = 1'b0;
      end
      unique case (state_q)
        S_REQ: begin
          if (imem_ready) begin
            if (kill_q) begin
              kill_d = 1'b0;
            end else if (load_ok) begin
              instr_d    = imem_rdata;
              pc_d       = fetch_pc_q;
              valid_d    = 1'b1;
              fetch_pc_d = fetch_pc_q + 32'd4;
            end else begin
              skid_d     = imem_rdata;
              skid_pc_d  = fetch_pc_q;
              fetch_pc_d = fetch_pc_q + 32'd4;
              state_d    = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (load_ok) begin
            instr_d = skid_q;
            pc_d    = skid_pc_q;
            valid_d = 1'b1;
            state_d = S_REQ;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_REQ;
      fetch_pc_q  <= START_PC;
      kill_q      <= 1'b0;
      kill_addr_q <= START_PC;
      skid_q      <= NOP;
      skid_pc_q   <= START_PC;
      instr_q     <= NOP;
      pc_q        <= START_PC;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      kill_q      <= kill_d;
      kill_addr_q <= kill_addr_d;
      skid_q      <= skid_d;
      skid_pc_q   <= skid_pc_d;
      instr_q     <= instr_d;
      pc_q        <= pc_d;
      valid_q     <= valid_d;
    end
  end

  // gated so the request drops the instant reset asserts
  assign imem_req    = (state_q == S_REQ) && rst_n;
  assign imem_addr   = kill_q ? kill_addr_q : fetch_pc_q;
  assign Instr       = instr_q;
  assign PC          = pc_q;
  assign PCPlus4     = pc_q + 32'd4;
  assign Instr_valid = valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: queue-based fetch model checked every
// cycle, plus directed literal checks and a wrap-around instance.
module tb_instr_fetch_unit;

  localparam logic [31:0] MAGIC = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst1_n = 1'b0;
  logic        Stall = 1'b0;
  logic        PCSrc = 1'b0;
  logic [31:0] PCTarget = 32'h0;
  int          lat = 0;
  int          lat_cnt;

  logic        imem_req, imem_ready, Instr_valid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] Instr, PC, PCPlus4;

  logic        req1, rdy1, v1;
  logic [31:0] addr1, rdata1, instr1, pc1, pc41;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .PCSrc(PCSrc), .PCTarget(PCTarget),
    .Stall(Stall),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .Instr(Instr), .PC(PC), .PCPlus4(PCPlus4),
    .Instr_valid(Instr_valid)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .rst_n(rst1_n),
    .PCSrc(1'b0), .PCTarget(32'h0),
    .Stall(1'b0),
    .imem_req(req1), .imem_addr(addr1),
    .imem_rdata(rdata1), .imem_ready(rdy1),
    .Instr(instr1), .PC(pc1), .PCPlus4(pc41),
    .Instr_valid(v1)
  );

  // memory: answers after lat waiting cycles
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) lat_cnt <= 0;
    else if (!imem_req || imem_ready) lat_cnt <= 0;
    else lat_cnt <= lat_cnt + 1;
  end

  assign imem_ready = imem_req && (lat_cnt >= lat);
  assign imem_rdata = imem_addr ^ MAGIC;
  assign rdy1       = req1;
  assign rdata1     = addr1 ^ MAGIC;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic check1(input string name,
                        input logic act,
                        input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b want %b", name, act, exp);
  endtask

  // model: words fetched but not yet consumed (output + skid)
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } word_t;

  word_t       q[$];
  word_t       m_w;
  logic [31:0] m_next, m_kaddr, m_a;
  bit          m_kill, m_req, m_fire, m_redir;

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_next = 32'h0;
      m_kaddr = 32'h0;
      m_kill = 1'b0;
    end else begin
      m_req   = (q.size() < 2);
      m_a     = m_kill ? m_kaddr : m_next;
      m_fire  = m_req && imem_ready;
      m_redir = PCSrc && !Stall;
      if (q.size() > 0 && !Stall) void'(q.pop_front());
      if (m_redir) begin
        q.delete();
        if (m_req && !m_fire && !m_kill) begin
          m_kill = 1'b1;
          m_kaddr = m_next;
        end else if (m_fire) begin
          m_kill = 1'b0;
        end
        m_next = PCTarget & 32'hFFFF_FFFC;
      end else if (m_fire) begin
        if (m_kill) begin
          m_kill = 1'b0;
        end else begin
          m_w.pc = m_a;
          m_w.ins = m_a ^ MAGIC;
          q.push_back(m_w);
          m_next = m_next + 32'd4;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check1("m_req", imem_req, q.size() < 2);
      if (q.size() < 2)
        check("m_addr", imem_addr,
              m_kill ? m_kaddr : m_next);
      check1("m_valid", Instr_valid, q.size() > 0);
      if (q.size() > 0) begin
        check("m_pc", PC, q[0].pc);
        check("m_instr", Instr, q[0].ins);
        check("m_pcplus4", PCPlus4, q[0].pc + 32'd4);
      end
    end
  end

  task automatic wait_valid(input int maxc,
                            input string name);
    int n = 0;
    while (!Instr_valid && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check1(name, Instr_valid, 1'b1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check1("rst_req", imem_req, 1'b0);
    check1("rst_valid", Instr_valid, 1'b0);
    check("rst_instr", Instr, 32'h0000_0013);
    check("rst_pc", PC, 32'h0);
    check("rst_pcplus4", PCPlus4, 32'h4);
    #2 rst_n = 1'b1;

    @(negedge clk);
    check1("first_valid", Instr_valid, 1'b1);
    check("first_pc", PC, 32'h0);
    check("first_instr", Instr, 32'hA5A5_0000);
    @(negedge clk);
    check("seq_pc4", PC, 32'h4);
    @(negedge clk);
    check("seq_pc8", PC, 32'h8);
    check("seq_instr8", Instr, 32'hA5A5_0008);

    #1 lat = 2;
    @(negedge clk);
    check("wait_addr1", imem_addr, 32'hC);
    check1("wait_valid1", Instr_valid, 1'b0);
    @(negedge clk);
    check("wait_addr2", imem_addr, 32'hC);
    check1("wait_req2", imem_req, 1'b1);
    @(negedge clk);
    check("lat_pc", PC, 32'hC);
    check1("lat_valid", Instr_valid, 1'b1);

    #1 lat = 0;
    Stall = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("stall_pc", PC, 32'hC);
      check1("stall_req", imem_req, 1'b0);
    end
    #1 Stall = 1'b0;
    @(negedge clk);
    check("skid_pc", PC, 32'h10);
    check("skid_instr", Instr, 32'hA5A5_0010);
    @(negedge clk);
    check("after_skid_pc", PC, 32'h14);

    #1 lat = 2;
    @(negedge clk);
    check1("pend_valid", Instr_valid, 1'b0);
    check("pend_addr", imem_addr, 32'h18);
    #1 PCSrc = 1'b1;
    PCTarget = 32'h103;
    @(negedge clk);
    check("kill_addr", imem_addr, 32'h18);
    check1("kill_valid", Instr_valid, 1'b0);
    #1 PCSrc = 1'b0;
    wait_valid(10, "redir_timeout");
    check("redir_pc", PC, 32'h100);
    check("redir_instr", Instr, 32'hA5A5_0100);

    #1 lat = 0;
    PCSrc = 1'b1;
    PCTarget = 32'h200;
    @(negedge clk);
    check1("race_valid", Instr_valid, 1'b0);
    check("race_addr", imem_addr, 32'h200);
    #1 PCSrc = 1'b0;
    @(negedge clk);
    check("race_pc", PC, 32'h200);
    check("race_instr", Instr, 32'hA5A5_0200);

    #1 Stall = 1'b1;
    PCSrc = 1'b1;
    PCTarget = 32'h300;
    @(negedge clk);
    check1("ign_valid", Instr_valid, 1'b1);
    check("ign_pc", PC, 32'h200);
    #1 Stall = 1'b0;
    PCSrc = 1'b0;
    @(negedge clk);
    check("ign_next_pc", PC, 32'h204);

    #1 lat = 3;
    Stall = 1'b1;
    @(negedge clk);
    check("mid_addr", imem_addr, 32'h208);
    check1("mid_req", imem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check1("arst_req", imem_req, 1'b0);
    check1("arst_valid", Instr_valid, 1'b0);
    check("arst_instr", Instr, 32'h0000_0013);
    check("arst_pc", PC, 32'h0);
    repeat (2) @(negedge clk);
    Stall = 1'b0;
    lat = 0;
    #2 rst_n = 1'b1;
    @(negedge clk);
    check1("restart_valid", Instr_valid, 1'b1);
    check("restart_pc", PC, 32'h0);
    @(negedge clk);
    check("restart_pc4", PC, 32'h4);

    #2 rst1_n = 1'b1;
    @(negedge clk);
    check1("wrap_valid", v1, 1'b1);
    check("wrap_pc", pc1, 32'hFFFF_FFFC);
    check("wrap_pcplus4", pc41, 32'h0);
    check("wrap_instr", instr1, 32'h5A5A_FFFC);
    @(negedge clk);
    check("wrap_pc0", pc1, 32'h0);
    check("wrap_pc0_plus4", pc41, 32'h4);
    check("wrap_instr0", instr1, 32'hA5A5_0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
